lt_array: RTL and testbench



---
 rtl/lt_array.sv | 116 +++++++++++
 tb/tb_lt_array.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lt_array.sv
// ============================================================================
// lt_array : multi-channel gamma-framed temporal less-than (race logic / TNN)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module lt_array #(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic            aclk,
  input  logic            grst_n,
  input  logic            mode_le,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] b,
  output logic [N_CH-1:0] q,
  output logic            gamma_tick,
  output logic [N_CH-1:0] lt_result
);

  localparam int c_gw = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int c_pw = $clog2(PULSE_WIDTH + 1);
  localparam logic [c_gw-1:0] c_glast = c_gw'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [c_pw-1:0] c_pload = c_pw'(PULSE_WIDTH);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_FIRE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [c_gw-1:0] r_gcnt;
  logic [N_CH-1:0] r_prev_a;
  logic [N_CH-1:0] r_prev_b;
  logic [N_CH-1:0] w_ea;
  logic [N_CH-1:0] w_eb;
  logic            w_tick;

  assign w_tick     = (r_gcnt == c_glast);
  assign gamma_tick = w_tick;
  assign w_ea       = a & ~r_prev_a;
  assign w_eb       = b & ~r_prev_b;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_gcnt   <= '0;
      r_prev_a <= '0;
      r_prev_b <= '0;
    end else begin
      r_gcnt   <= w_tick ? '0 : r_gcnt + 1'b1;
      r_prev_a <= a;
      r_prev_b <= b;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t          r_state;
    logic [c_pw-1:0] r_pcnt;
    logic            r_q;
    logic            r_fired;
    logic            r_lt;

    // The boundary wins over every FSM transition and swallows edges in that cycle.
    always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
        r_state <= S_WAIT;
        r_pcnt  <= '0;
        r_q     <= 1'b0;
        r_fired <= 1'b0;
        r_lt    <= 1'b0;
      end else if (w_tick) begin
        r_state <= S_WAIT;
        r_pcnt  <= '0;
        r_q     <= 1'b0;
        r_lt    <= r_fired;
        r_fired <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (w_ea[i] && (!w_eb[i] || mode_le)) begin
              r_state <= S_FIRE;
              r_pcnt  <= c_pload;
              r_q     <= 1'b1;
              r_fired <= 1'b1;
            end else if (w_eb[i]) begin
              r_state <= S_DONE;
            end
          end
          S_FIRE: begin
            if (r_pcnt <= c_pw'(1)) begin
              r_state <= S_DONE;
              r_pcnt  <= '0;
              r_q     <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt - 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_WAIT;
            r_q     <= 1'b0;
          end
        endcase
      end
    end

    assign q[i]         = r_q;
    assign lt_result[i] = r_lt;
  end

endmodule

`default_nettype wire

// File: tb/tb_lt_array.sv
// ============================================================================
// tb_lt_array : directed self-checking bench for lt_array (N_CH=4, PW=4)
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_lt_array;

  logic       aclk = 1'b0;
  logic       grst_n = 1'b0;
  logic       mode_le = 1'b0;
  logic [3:0] a = 4'b0;
  logic [3:0] b = 4'b0;
  logic [3:0] q;
  logic       gamma_tick;
  logic [3:0] lt_result;

  int checks = 0;
  int errors = 0;
  int g = 0;

  lt_array #(
    .N_CH              (4),
    .GAMMA_CYCLE_WIDTH (16),
    .PULSE_WIDTH       (4)
  ) dut (
    .aclk       (aclk),
    .grst_n     (grst_n),
    .mode_le    (mode_le),
    .a          (a),
    .b          (b),
    .q          (q),
    .gamma_tick (gamma_tick),
    .lt_result  (lt_result)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // g tracks the expected gamma counter of the cycle that is currently open
  task automatic step();
    @(posedge aclk);
    #1;
    g = (g + 1) % 16;
  endtask

  task automatic go_to(input int k);
    for (int n = 0; n < 40 && g != k; n++) step();
  endtask

  initial begin
    #12;
    check("rst_q", q, 4'b0000);
    check("rst_lt", lt_result, 4'b0000);
    check("rst_tick", {3'b0, gamma_tick}, 4'b0000);
    @(posedge aclk); #1;
    grst_n = 1'b1;
    g = 0;
    check("rel_tick", {3'b0, gamma_tick}, 4'b0000);

    // gamma 0: ch0 a wins, ch1 b wins, ch2 strict tie, ch3 truncated
    go_to(2);  b[1] = 1'b1;
    go_to(3);  a[0] = 1'b1;
    check("g0_q_at3", q, 4'b0000);
    go_to(4);  check("g0_q_at4", q, 4'b0001);
    go_to(5);  a[1] = 1'b1;
    go_to(6);  a[2] = 1'b1; b[2] = 1'b1; mode_le = 1'b0;
    go_to(7);  b[0] = 1'b1;
    check("g0_q_at7", q, 4'b0001);
    go_to(8);  check("g0_q_at8", q, 4'b0000);
    go_to(13); a[3] = 1'b1;
    go_to(14); check("g0_q_at14", q, 4'b1000);
    a[2:0] = 3'b000; b = 4'b0000;
    go_to(15);
    check("g0_tick15", {3'b0, gamma_tick}, 4'b0001);
    check("g0_q_at15", q, 4'b1000);
    check("g0_lt_hold", lt_result, 4'b0000);
    a[0] = 1'b1;
    go_to(0);
    check("g1_q_at0", q, 4'b0000);
    check("g0_lt", lt_result, 4'b1001);
    check("g1_tick0", {3'b0, gamma_tick}, 4'b0000);

    // gamma 1: held levels give no edges, ch2 tie with mode_le=1 fires
    go_to(1);  check("g1_q_at1", q, 4'b0000);
    go_to(6);  a[2] = 1'b1; b[2] = 1'b1; mode_le = 1'b1;
    go_to(7);  check("g1_q_at7", q, 4'b0100);
    go_to(10); check("g1_q_at10", q, 4'b0100);
    go_to(11); check("g1_q_at11", q, 4'b0000);
    go_to(12); a = 4'b0000; b = 4'b0000; mode_le = 1'b0;
    go_to(14); check("g1_q_at14", q, 4'b0000);
    go_to(0);  check("g1_lt", lt_result, 4'b0100);

    // gamma 2: toggling a[0] yields one pulse
    go_to(2);  a[0] = 1'b1;
    go_to(3);  check("g2_q_at3", q, 4'b0001);
    go_to(4);  a[0] = 1'b0;
    go_to(5);  a[0] = 1'b1;
    go_to(6);  check("g2_q_at6", q, 4'b0001);
    go_to(7);  check("g2_q_at7", q, 4'b0000);
    go_to(8);  a = 4'b0000;
    go_to(10); check("g2_q_at10", q, 4'b0000);
    go_to(0);  check("g2_lt", lt_result, 4'b0001);

    // gamma 3: all channels fire together, then reset mid-pulse
    go_to(2);  a = 4'b1111;
    go_to(3);  check("g3_q_at3", q, 4'b1111);
    go_to(5);  check("g3_q_at5", q, 4'b1111);
    grst_n = 1'b0;
    a = 4'b0000;
    #1;
    check("mrst_q", q, 4'b0000);
    check("mrst_lt", lt_result, 4'b0000);
    check("mrst_tick", {3'b0, gamma_tick}, 4'b0000);
    @(posedge aclk); #1;
    check("mrst_hold_q", q, 4'b0000);
    grst_n = 1'b1;
    g = 0;
    go_to(14); check("post_tick14", {3'b0, gamma_tick}, 4'b0000);
    go_to(15); check("post_tick15", {3'b0, gamma_tick}, 4'b0001);
    go_to(0);
    check("post_lt", lt_result, 4'b0000);
    check("post_q", q, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
